// File: rtl/fifo_uart_tx_pkg.sv
// ============================================================================
// Module   : fifo_uart_tx_pkg
// Brief    : Shared word geometry and UART frame constants for fifo_uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_uart_tx_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int UART_FRAME_BITS = 10;
  localparam int NBYTES          = DATA_WIDTH / 8;
  localparam int BYTE_IDX_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  // Byte idx of a word, byte 0 being the least-significant one.
  function automatic logic [7:0] word_byte(
    input logic [DATA_WIDTH-1:0] word,
    input logic [BYTE_IDX_W-1:0] idx
  );
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_uart_tx_baud_counter.sv
// ============================================================================
// Module   : baud_counter
// Brief    : Free-running bit-period counter; tick marks the last cycle of a bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] c_TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear || (r_count == c_TERMINAL)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == c_TERMINAL);

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Pops words from the CPU output FIFO and sends them LSB byte first
//            as back-to-back 8N1 frames on the UART TX pin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  output logic                  tx,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  localparam logic [BYTE_IDX_W-1:0] c_LAST_BYTE = BYTE_IDX_W'(NBYTES - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_word;
  logic [BYTE_IDX_W-1:0] r_byte_idx;
  logic [2:0]            r_bit_idx;
  logic                  r_tx;
  logic                  w_tx_next;
  logic                  w_tick;
  logic                  w_clear;
  logic [7:0]            w_cur_byte;

  assign w_cur_byte = word_byte(r_word, r_byte_idx);

  // Every state change restarts the bit period, so each state starts aligned.
  assign w_clear = (w_next_state != r_state);

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_tx_next    = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (!fifo_empty) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_next_state = S_START;
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_tick) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        w_tx_next = w_cur_byte[r_bit_idx];
        if (w_tick && (r_bit_idx == 3'd7)) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_next_state = (r_byte_idx == c_LAST_BYTE) ? S_IDLE : S_START;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word     <= '0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx <= w_tx_next;
      unique case (r_state)
        S_LOAD: begin
          r_word     <= fifo_data_out;
          r_byte_idx <= '0;
        end
        S_START: begin
          if (w_tick) begin
            r_bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          if (w_tick && (r_byte_idx != c_LAST_BYTE)) begin
            r_byte_idx <= r_byte_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fifo_read = (r_state == S_FETCH);
  assign busy      = (r_state != S_IDLE);
  assign tx        = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : FIFO model, UART line receiver and byte scoreboard for fifo_uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;
  import fifo_uart_tx_pkg::*;

  localparam int CPB   = 4;
  localparam int FRAME = UART_FRAME_BITS * CPB;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [DATA_WIDTH-1:0] fifo_data_out = '0;
  logic                  fifo_empty = 1'b1;
  logic                  fifo_read;
  logic                  tx;
  logic                  busy;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_data_out(fifo_data_out),
    .fifo_empty   (fifo_empty),
    .fifo_read    (fifo_read),
    .tx           (tx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic [DATA_WIDTH-1:0] fifo_q[$];
  logic [7:0]            exp_q[$];
  int                    read_q[$];
  int                    start_q[$];
  bit                    toggle_mode = 1'b0;
  bit                    pend = 1'b0;
  logic [DATA_WIDTH-1:0] pend_word;

  task automatic push_word(input logic [DATA_WIDTH-1:0] w);
    fifo_q.push_back(w);
    for (int i = 0; i < NBYTES; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // FIFO model: data is valid only in the cycle after the pop, garbage otherwise.
  initial forever begin
    @(negedge clk);
    if (pend) begin
      fifo_data_out = pend_word;
      pend = 1'b0;
    end else begin
      fifo_data_out = DATA_WIDTH'($urandom);
    end
    if (fifo_read === 1'b1) begin
      read_q.push_back(cyc);
      check("no_underflow", 64'(fifo_q.size() != 0), 64'(1));
      if (fifo_q.size() != 0) begin
        pend_word = fifo_q.pop_front();
        pend = 1'b1;
      end
    end
    if (toggle_mode && busy) fifo_empty = 1'($urandom_range(0, 1));
    else                     fifo_empty = (fifo_q.size() == 0);
  end

  // Line receiver: samples each bit on its first cycle, requires it stable after.
  logic       tx_prev = 1'b1;
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  int         rx_bi = 0;
  logic [9:0] rx_bits = '0;
  bit         rx_unstable = 1'b0;
  int         n_frames = 0;
  int         last_start = 0;
  logic [7:0] exp_b;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      rx_active = 1'b0;
      n_frames  = 0;
      tx_prev   = 1'b1;
    end else begin
      if (!rx_active && tx_prev && !tx) begin
        rx_active   = 1'b1;
        rx_cnt      = 0;
        rx_unstable = 1'b0;
        rx_bits     = '0;
        if (n_frames % NBYTES != 0)
          check("intra_word_frame_spacing", 64'(cyc - last_start), 64'(FRAME));
        last_start = cyc;
        start_q.push_back(cyc);
      end
      if (rx_active) begin
        rx_bi = rx_cnt / CPB;
        if (rx_cnt % CPB == 0) rx_bits[rx_bi] = tx;
        else if (tx !== rx_bits[rx_bi]) rx_unstable = 1'b1;
        if (rx_cnt == FRAME - 1) begin
          rx_active = 1'b0;
          n_frames++;
          check("frame_was_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check("frame_bits", 64'({rx_unstable, rx_bits}), 64'({1'b0, 1'b1, exp_b, 1'b0}));
          end
        end
        rx_cnt++;
      end
      tx_prev = tx;
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    repeat (4) @(negedge clk);
    while ((busy || fifo_q.size() != 0 || rx_active || pend) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completes"}, 64'(n < budget), 64'(1));
    repeat (3) @(negedge clk);
    check({name, "_all_bytes_sent"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic quiet_window(input string name, input int cycles);
    int bad = 0;
    int r0  = read_q.size();
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_read !== 1'b0 || busy !== 1'b0) bad++;
    end
    check({name, "_bad_cycles"}, 64'(bad), 64'(0));
    check({name, "_no_pops"}, 64'(read_q.size() - r0), 64'(0));
  endtask

  initial begin
    int n0;
    int s0;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 64'(tx), 64'(1));
    check("reset_fifo_read", 64'(fifo_read), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Empty FIFO: line stays idle.
    quiet_window("idle_empty", 100);

    // Single word 0x000000A5 with exact latency and busy window.
    @(posedge clk);
    #2;
    push_word(32'h0000_00A5);
    n0 = read_q.size();
    @(posedge clk); @(negedge clk);
    check("fetch_read", 64'(fifo_read), 64'(1));
    check("fetch_busy", 64'(busy), 64'(1));
    @(posedge clk); @(negedge clk);
    check("load_read_low", 64'(fifo_read), 64'(0));
    check("load_tx_high", 64'(tx), 64'(1));
    @(posedge clk); @(negedge clk);
    check("k2_tx_high", 64'(tx), 64'(1));
    @(posedge clk); @(negedge clk);
    check("k3_start_bit", 64'(tx), 64'(0));
    repeat (158) @(posedge clk);
    @(negedge clk);
    check("busy_last_stop", 64'(busy), 64'(1));
    @(posedge clk); @(negedge clk);
    check("busy_falls_at_idle", 64'(busy), 64'(0));
    wait_done("word_a5", 400);
    check("word_a5_pops", 64'(read_q.size() - n0), 64'(1));

    // Two queued words: back-to-back with a 3-cycle gap.
    @(posedge clk);
    #2;
    n0 = read_q.size();
    s0 = start_q.size();
    push_word(32'h4443_4241);
    push_word(32'h0000_0A0D);
    wait_done("two_words", 800);
    check("two_words_pops", 64'(read_q.size() - n0), 64'(2));
    check("two_words_frames", 64'(start_q.size() - s0), 64'(2 * NBYTES));
    if (start_q.size() >= s0 + 2 * NBYTES)
      check("inter_word_gap", 64'(start_q[s0+NBYTES] - start_q[s0+NBYTES-1]), 64'(FRAME + 3));
    if (read_q.size() >= n0 + 2)
      check("two_words_pop_spacing", 64'(read_q[n0+1] - read_q[n0]), 64'(NBYTES * FRAME + 3));

    // Reset in the middle of byte 1, data bit 3.
    @(posedge clk);
    #2;
    n0 = read_q.size();
    push_word(DATA_WIDTH'($urandom));
    n = 0;
    while (read_q.size() == n0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midreset_pop_seen", 64'(read_q.size() - n0), 64'(1));
    repeat (59) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_tx", 64'(tx), 64'(1));
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_read", 64'(fifo_read), 64'(0));
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    quiet_window("after_reset", 100);

    // fifo_empty chatter while busy must not trigger pops or disturb bits.
    @(posedge clk);
    #2;
    n0 = read_q.size();
    toggle_mode = 1'b1;
    push_word(DATA_WIDTH'($urandom));
    wait_done("toggle_empty", 400);
    toggle_mode = 1'b0;
    check("toggle_empty_pops", 64'(read_q.size() - n0), 64'(1));

    // Continuously non-empty: pops exactly one word period plus 3 apart.
    @(posedge clk);
    #2;
    n0 = read_q.size();
    for (int i = 0; i < 4; i++) push_word(DATA_WIDTH'($urandom));
    wait_done("stream", 1500);
    check("stream_pops", 64'(read_q.size() - n0), 64'(4));
    for (int i = 1; i < 4; i++)
      if (read_q.size() >= n0 + 4)
        check("stream_pop_spacing", 64'(read_q[n0+i] - read_q[n0+i-1]), 64'(163));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
